// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: stall-vector encodings,
// FSM state encoding and the zero word used for reset values.
package pipe_ctrl_pkg;

    // Stall vectors, bit order [0]=PC [1]=IF [2]=ID [3]=EX [4]=MEM [5]=WB
    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_IF   = 6'b000011;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    // RUN: redirects go straight out; PEND: a redirect waits for fetch to unfreeze
    typedef enum logic {
        RUN  = 1'b0,
        PEND = 1'b1
    } state_t;

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter used for the controller's performance counters.
// It stops at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count up on each qualified edge, holding once the maximum is reached
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline controller: merges per-stage stall requests into the
// stall vector, sequences branch redirects (including ones that arrive
// while fetch is frozen) and keeps stall/flush performance counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              stallreq_if,
    input  logic              stallreq_id,
    input  logic              stallreq_ex,
    input  logic              stallreq_mem,
    input  logic              branch_flag,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [5:0]        stall,
    output logic              redirect_valid,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              flush_if,
    output logic              pend,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  flush_count
);

    state_t              state;
    state_t              state_next;
    logic [ADDR_W-1:0]   pend_pc;
    logic [ADDR_W-1:0]   pend_pc_next;
    logic [5:0]          stall_raw;
    logic                br_ok;
    logic                redirect_raw;
    logic [ADDR_W-1:0]   redirect_pc_raw;

    // Stall priority encoder: a deeper stage holding freezes everything upstream
    always_comb begin
        stall_raw = STALL_NONE;
        if (stallreq_mem) begin
            stall_raw = STALL_MEM;
        end else if (stallreq_ex) begin
            stall_raw = STALL_EX;
        end else if (stallreq_id) begin
            stall_raw = STALL_ID;
        end else if (stallreq_if) begin
            stall_raw = STALL_IF;
        end
    end

    // A branch is only trusted when ID is actually advancing this cycle
    assign br_ok = branch_flag & ~stall_raw[2];

    // State and pending-target registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= RUN;
            pend_pc <= ZERO_WORD[ADDR_W-1:0];
        end else begin
            state   <= state_next;
            pend_pc <= pend_pc_next;
        end
    end

    // Next-state and redirect decode; PEND ignores new branches because ID holds a bubble
    always_comb begin
        state_next      = state;
        pend_pc_next    = pend_pc;
        redirect_raw    = 1'b0;
        redirect_pc_raw = '0;
        unique case (state)
            RUN: begin
                if (br_ok && !stall_raw[1]) begin
                    redirect_raw    = 1'b1;
                    redirect_pc_raw = branch_target;
                end else if (br_ok && stall_raw[1]) begin
                    pend_pc_next = branch_target;
                    state_next   = PEND;
                end
            end
            PEND: begin
                if (!stall_raw[1]) begin
                    redirect_raw    = 1'b1;
                    redirect_pc_raw = pend_pc;
                    state_next      = RUN;
                end
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    // All combinational outputs are forced low while reset is held
    always_comb begin
        stall          = RST ? STALL_NONE : stall_raw;
        redirect_valid = redirect_raw & ~RST;
        redirect_pc    = RST ? '0 : redirect_pc_raw;
        flush_if       = redirect_raw & ~RST;
        pend           = (state == PEND) & ~RST;
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (stall != STALL_NONE),
        .count (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (flush_if),
        .count (flush_count)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed testbench for pipe_ctrl: one task per scenario, inline checks,
// plus a narrow-counter instance to exercise saturation.
module tb_pipe_ctrl;

    logic        CLK;
    logic        RST;
    logic        stallreq_if;
    logic        stallreq_id;
    logic        stallreq_ex;
    logic        stallreq_mem;
    logic        branch_flag;
    logic [31:0] branch_target;

    logic [5:0]  stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush_if;
    logic        pend;
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;

    logic [5:0]  s_stall;
    logic        s_redirect_valid;
    logic [31:0] s_redirect_pc;
    logic        s_flush_if;
    logic        s_pend;
    logic [3:0]  s_stall_cycles;
    logic [3:0]  s_flush_count;

    int total;
    int passed;

    pipe_ctrl #(.ADDR_W(32), .CNT_W(32)) dut (
        .CLK            (CLK),
        .RST            (RST),
        .stallreq_if    (stallreq_if),
        .stallreq_id    (stallreq_id),
        .stallreq_ex    (stallreq_ex),
        .stallreq_mem   (stallreq_mem),
        .branch_flag    (branch_flag),
        .branch_target  (branch_target),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush_if       (flush_if),
        .pend           (pend),
        .stall_cycles   (stall_cycles),
        .flush_count    (flush_count)
    );

    pipe_ctrl #(.ADDR_W(32), .CNT_W(4)) dut_small (
        .CLK            (CLK),
        .RST            (RST),
        .stallreq_if    (stallreq_if),
        .stallreq_id    (stallreq_id),
        .stallreq_ex    (stallreq_ex),
        .stallreq_mem   (stallreq_mem),
        .branch_flag    (branch_flag),
        .branch_target  (branch_target),
        .stall          (s_stall),
        .redirect_valid (s_redirect_valid),
        .redirect_pc    (s_redirect_pc),
        .flush_if       (s_flush_if),
        .pend           (s_pend),
        .stall_cycles   (s_stall_cycles),
        .flush_count    (s_flush_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Advance one clock; inputs are changed 2 time units after the edge
    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic clear_inputs();
        stallreq_if   = 1'b0;
        stallreq_id   = 1'b0;
        stallreq_ex   = 1'b0;
        stallreq_mem  = 1'b0;
        branch_flag   = 1'b0;
        branch_target = 32'h0;
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        clear_inputs();
        RST           = 1'b1;
        stallreq_mem  = 1'b1;
        branch_flag   = 1'b1;
        branch_target = 32'hDEAD_BEEF;
        tick();
        #1;
        total++; if (stall !== 6'b000000) $display("[TB] FAIL reset_stall got=%b exp=%b", stall, 6'b000000); else passed++;
        total++; if (redirect_valid !== 1'b0) $display("[TB] FAIL reset_rv got=%b exp=0", redirect_valid); else passed++;
        total++; if (redirect_pc !== 32'h0) $display("[TB] FAIL reset_rpc got=%h exp=0", redirect_pc); else passed++;
        total++; if (flush_if !== 1'b0) $display("[TB] FAIL reset_flush got=%b exp=0", flush_if); else passed++;
        total++; if (pend !== 1'b0) $display("[TB] FAIL reset_pend got=%b exp=0", pend); else passed++;
        total++; if (stall_cycles !== 32'd0) $display("[TB] FAIL reset_scnt got=%0d exp=0", stall_cycles); else passed++;
        total++; if (flush_count !== 32'd0) $display("[TB] FAIL reset_fcnt got=%0d exp=0", flush_count); else passed++;
        clear_inputs();
        RST = 1'b0;
        tick();
    endtask

    task automatic test_priority();
        $display("[TB] test_priority");
        stallreq_if  = 1'b1;
        stallreq_mem = 1'b1;
        #1;
        total++; if (stall !== 6'b011111) $display("[TB] FAIL prio_mem got=%b exp=%b", stall, 6'b011111); else passed++;
        tick();
        stallreq_mem = 1'b0;
        #1;
        total++; if (stall !== 6'b000011) $display("[TB] FAIL prio_if got=%b exp=%b", stall, 6'b000011); else passed++;
        stallreq_ex = 1'b1;
        stallreq_id = 1'b1;
        #1;
        total++; if (stall !== 6'b001111) $display("[TB] FAIL prio_ex got=%b exp=%b", stall, 6'b001111); else passed++;
        stallreq_ex = 1'b0;
        #1;
        total++; if (stall !== 6'b000111) $display("[TB] FAIL prio_id got=%b exp=%b", stall, 6'b000111); else passed++;
        stallreq_id = 1'b0;
        tick();
        clear_inputs();
        #1;
        total++; if (stall !== 6'b000000) $display("[TB] FAIL prio_none got=%b exp=%b", stall, 6'b000000); else passed++;
        total++; if (stall_cycles !== 32'd2) $display("[TB] FAIL prio_scnt got=%0d exp=2", stall_cycles); else passed++;
    endtask

    task automatic test_plain_branch();
        $display("[TB] test_plain_branch");
        branch_flag   = 1'b1;
        branch_target = 32'h0000_0040;
        #1;
        total++; if (redirect_valid !== 1'b1) $display("[TB] FAIL br_rv got=%b exp=1", redirect_valid); else passed++;
        total++; if (redirect_pc !== 32'h40) $display("[TB] FAIL br_rpc got=%h exp=00000040", redirect_pc); else passed++;
        total++; if (flush_if !== 1'b1) $display("[TB] FAIL br_flush got=%b exp=1", flush_if); else passed++;
        tick();
        clear_inputs();
        #1;
        total++; if (redirect_valid !== 1'b0) $display("[TB] FAIL br_rv_after got=%b exp=0", redirect_valid); else passed++;
        total++; if (redirect_pc !== 32'h0) $display("[TB] FAIL br_rpc_after got=%h exp=0", redirect_pc); else passed++;
        total++; if (flush_if !== 1'b0) $display("[TB] FAIL br_flush_after got=%b exp=0", flush_if); else passed++;
        total++; if (flush_count !== 32'd1) $display("[TB] FAIL br_fcnt got=%0d exp=1", flush_count); else passed++;
    endtask

    task automatic test_branch_if_stall();
        $display("[TB] test_branch_if_stall");
        stallreq_if   = 1'b1;
        branch_flag   = 1'b1;
        branch_target = 32'h100;
        #1;
        total++; if (redirect_valid !== 1'b0) $display("[TB] FAIL ifst_rv got=%b exp=0", redirect_valid); else passed++;
        total++; if (flush_if !== 1'b0) $display("[TB] FAIL ifst_flush got=%b exp=0", flush_if); else passed++;
        tick();
        #1;
        total++; if (pend !== 1'b1) $display("[TB] FAIL ifst_pend got=%b exp=1", pend); else passed++;
        for (int i = 0; i < 3; i++) begin
            branch_flag   = (i % 2 == 0) ? 1'b0 : 1'b1;
            branch_target = 32'h200;
            #1;
            total++; if (redirect_valid !== 1'b0 || pend !== 1'b1) $display("[TB] FAIL ifst_hold%0d rv=%b pend=%b exp rv=0 pend=1", i, redirect_valid, pend); else passed++;
            tick();
        end
        stallreq_if = 1'b0;
        branch_flag = 1'b1;
        #1;
        total++; if (redirect_valid !== 1'b1) $display("[TB] FAIL ifst_rv_rel got=%b exp=1", redirect_valid); else passed++;
        total++; if (redirect_pc !== 32'h100) $display("[TB] FAIL ifst_rpc got=%h exp=00000100", redirect_pc); else passed++;
        total++; if (flush_if !== 1'b1) $display("[TB] FAIL ifst_flush_rel got=%b exp=1", flush_if); else passed++;
        tick();
        clear_inputs();
        #1;
        total++; if (pend !== 1'b0 || redirect_valid !== 1'b0) $display("[TB] FAIL ifst_run pend=%b rv=%b exp 0 0", pend, redirect_valid); else passed++;
        total++; if (flush_count !== 32'd2) $display("[TB] FAIL ifst_fcnt got=%0d exp=2", flush_count); else passed++;
        total++; if (stall_cycles !== 32'd6) $display("[TB] FAIL ifst_scnt got=%0d exp=6", stall_cycles); else passed++;
    endtask

    task automatic test_branch_id_hold();
        $display("[TB] test_branch_id_hold");
        stallreq_id   = 1'b1;
        branch_flag   = 1'b1;
        branch_target = 32'h80;
        #1;
        total++; if (stall !== 6'b000111) $display("[TB] FAIL idh_stall got=%b exp=%b", stall, 6'b000111); else passed++;
        total++; if (redirect_valid !== 1'b0) $display("[TB] FAIL idh_rv got=%b exp=0", redirect_valid); else passed++;
        tick();
        #1;
        total++; if (pend !== 1'b0) $display("[TB] FAIL idh_pend got=%b exp=0", pend); else passed++;
        stallreq_id = 1'b0;
        #1;
        total++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h80) $display("[TB] FAIL idh_rel rv=%b rpc=%h exp 1 00000080", redirect_valid, redirect_pc); else passed++;
        tick();
        clear_inputs();
        #1;
        total++; if (flush_count !== 32'd3) $display("[TB] FAIL idh_fcnt got=%0d exp=3", flush_count); else passed++;
    endtask

    task automatic test_back_to_back();
        $display("[TB] test_back_to_back");
        branch_flag   = 1'b1;
        branch_target = 32'h10;
        #1;
        total++; if (redirect_pc !== 32'h10 || flush_if !== 1'b1) $display("[TB] FAIL b2b_first rpc=%h flush=%b exp 00000010 1", redirect_pc, flush_if); else passed++;
        tick();
        branch_target = 32'h20;
        #1;
        total++; if (redirect_pc !== 32'h20 || flush_if !== 1'b1) $display("[TB] FAIL b2b_second rpc=%h flush=%b exp 00000020 1", redirect_pc, flush_if); else passed++;
        tick();
        clear_inputs();
        #1;
        total++; if (flush_count !== 32'd5) $display("[TB] FAIL b2b_fcnt got=%0d exp=5", flush_count); else passed++;
    endtask

    task automatic test_reset_mid_pend();
        $display("[TB] test_reset_mid_pend");
        stallreq_if   = 1'b1;
        branch_flag   = 1'b1;
        branch_target = 32'h300;
        tick();
        #1;
        total++; if (pend !== 1'b1) $display("[TB] FAIL rmp_pend_enter got=%b exp=1", pend); else passed++;
        branch_flag = 1'b0;
        RST = 1'b1;
        #1;
        total++; if (stall !== 6'b000000 || pend !== 1'b0 || redirect_valid !== 1'b0) $display("[TB] FAIL rmp_async stall=%b pend=%b rv=%b exp 000000 0 0", stall, pend, redirect_valid); else passed++;
        total++; if (stall_cycles !== 32'd0 || flush_count !== 32'd0) $display("[TB] FAIL rmp_cnt_clr scnt=%0d fcnt=%0d exp 0 0", stall_cycles, flush_count); else passed++;
        tick();
        RST = 1'b0;
        #1;
        total++; if (pend !== 1'b0 || stall !== 6'b000011) $display("[TB] FAIL rmp_after pend=%b stall=%b exp 0 000011", pend, stall); else passed++;
        tick();
        stallreq_if = 1'b0;
        #1;
        total++; if (redirect_valid !== 1'b0 || flush_if !== 1'b0) $display("[TB] FAIL rmp_no_redirect rv=%b flush=%b exp 0 0", redirect_valid, flush_if); else passed++;
        total++; if (stall_cycles !== 32'd1) $display("[TB] FAIL rmp_scnt got=%0d exp=1", stall_cycles); else passed++;
        tick();
    endtask

    task automatic test_saturation();
        $display("[TB] test_saturation");
        clear_inputs();
        RST = 1'b1;
        #1;
        RST = 1'b0;
        stallreq_mem = 1'b1;
        for (int i = 0; i < 14; i++) tick();
        #1;
        total++; if (s_stall_cycles !== 4'hE) $display("[TB] FAIL sat_pre got=%h exp=e", s_stall_cycles); else passed++;
        for (int i = 0; i < 6; i++) tick();
        #1;
        total++; if (s_stall_cycles !== 4'hF) $display("[TB] FAIL sat_hold got=%h exp=f", s_stall_cycles); else passed++;
        total++; if (stall_cycles !== 32'd20) $display("[TB] FAIL sat_wide got=%0d exp=20", stall_cycles); else passed++;
        total++; if (s_flush_count !== 4'h0) $display("[TB] FAIL sat_fcnt got=%h exp=0", s_flush_count); else passed++;
        clear_inputs();
        tick();
    endtask

    initial begin
        total  = 0;
        passed = 0;
        RST    = 1'b1;
        clear_inputs();
        test_reset();
        test_priority();
        test_plain_branch();
        test_branch_if_stall();
        test_branch_id_hold();
        test_back_to_back();
        test_reset_mid_pend();
        test_saturation();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline controller for the 5-stage RISC-V core. It merges the per-stage stall requests into the stall[5:0] vector consumed by the PC register and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It sequences branch redirects, including redirects that arrive while fetch is frozen. It also keeps saturating stall and flush performance counters.

Parameters:
ADDR_W, 32, PC/target width (matches ADDR_WIDTH)
CNT_W, 32, width of performance counters

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset; asynchronous, active-high
stallreq_if  in  1  instruction memory not ready
stallreq_id  in  1  load-use hazard detected in ID
stallreq_ex  in  1  multi-cycle EX op busy
stallreq_mem  in  1  data memory not ready
branch_flag  in  1  branch/jump taken, resolved in ID
branch_target  in  ADDR_W  target of taken branch
stall  out  6  [0]=PC [1]=IF [2]=ID [3]=EX [4]=MEM [5]=WB; 1 = hold
redirect_valid  out  1  PC must load redirect_pc this cycle
redirect_pc  out  ADDR_W  redirect target
flush_if  out  1  IF/ID must capture a bubble this cycle
pend  out  1  redirect pending (state==PEND)
stall_cycles  out  CNT_W  cycles with stall!=0, saturating
flush_count  out  CNT_W  number of flush_if pulses, saturating

Behaviour:
- Reset: state=RUN, pend_pc=0, both counters=0. While RST=1, all outputs are 0.
- Stall vector is combinational. Priority is highest first:
  - mem: 6'b011111
  - ex: 6'b001111
  - id: 6'b000111
  - if: 6'b000011
  - none: 6'b000000
- WB is never stalled (stall[5]=0 always).
- Branch qualification: br_ok = branch_flag & ~stall[2].
  - When ID is held, branch_flag is ignored; ID reasserts it once it advances.
- FSM state RUN:
  - br_ok & ~stall[1]: redirect_valid=1, redirect_pc=branch_target, flush_if=1, all combinational in the same cycle. Stay in RUN.
  - br_ok & stall[1] (IF-only stall): latch pend_pc<=branch_target and go to PEND. No redirect or flush this cycle.
- FSM state PEND:
  - pend=1.
  - While stall[1]=1: hold. Any branch_flag is ignored and pend_pc is unchanged.
  - First cycle with stall[1]=0: redirect_valid=1, redirect_pc=pend_pc, flush_if=1, then go to RUN.
  - In that same cycle, a new br_ok is ignored. The ID instruction is the bubble from the IF-stall, so it cannot be a valid branch.
- When no redirect is issued, redirect_pc=0.
- Redirect latency: 0 cycles in RUN; in PEND, issued on the first cycle stall[1] drops.
- Counters:
  - stall_cycles += 1 on every clock edge with stall!=0.
  - flush_count += 1 on every clock edge with flush_if=1.
  - Both saturate at all-ones; no wrap.
- Reset mid-PEND: pending redirect is discarded, state returns to RUN, and counters clear.
- Simultaneous requests: the highest-priority stall wins. A branch with only stallreq_if active goes to PEND. A branch with id/ex/mem stall active is ignored.

Decomposition:
- Stall-vector constants (STALL_NONE/IF/ID/EX/MEM), the state encoding (RUN=1'b0, PEND=1'b1) and ZeroWord belong in the shared config.vh.
- Sub-module sat_counter (parameter W; ports CLK, RST, inc, count) is instantiated twice for the performance counters.
- The stall priority encoder stays inline.

Test Plan:
1. Request priority: assert stallreq_if+stallreq_mem together -> stall=6'b011111. Drop mem -> 6'b000011. Drop all -> 6'b000000. stall_cycles ends at 2 after two stalled cycles.
2. Plain branch: no stalls, branch_flag=1, target=32'h0000_0040 -> same cycle redirect_valid=1, redirect_pc=32'h40, flush_if=1. Next cycle, with branch_flag deasserted, all outputs return to 0 and flush_count=1.
3. Branch during IF stall: stallreq_if=1, branch_flag=1 target=32'h100 -> no redirect, pend=1. Hold stallreq_if 3 more cycles with branch_flag toggling (target=32'h200) -> pend_pc stays 32'h100. Drop stallreq_if -> one-cycle redirect to 32'h100, flush_if=1, back to RUN.
4. Branch under ID hold: stallreq_id=1, branch_flag=1 -> stall=6'b000111, no redirect, stays in RUN. Release stallreq_id with branch_flag still 1 -> redirect issued that cycle.
5. Reset mid-PEND: enter PEND, assert RST asynchronously mid-cycle -> outputs 0 immediately. After release: state=RUN, counters=0, and no redirect when stallreq_if later drops.
6. Saturation: force counters near the max with CNT_W=4, run 20 stalled cycles -> stall_cycles holds at 4'hF.
